// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding memory read at a time, feeding a
// single-entry instruction register with a valid/ready handoff and redirect flush.
module instr_fetch_unit #(
  parameter int            AW       = 16,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [15:0]   mem_rdata,
  output logic          ir_valid,
  input  logic          ir_ready,
  output logic [7:0]    ir_opcode,
  output logic [7:0]    ir_operand,
  output logic [AW-1:0] ir_pc,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic          r_run;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_tgt;
  logic [AW-1:0] r_ir_pc;
  logic [15:0]   r_ir;
  logic [AW-1:0] w_pc_next;
  logic [AW-1:0] w_tgt_next;
  logic          w_load_ir;
  logic          w_ack;

  // r_run keeps the request low until the first edge after reset release,
  // so an ack seen before any request was issued is never taken as data.
  assign w_ack = mem_ack & r_run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_pc_next    = r_pc;
    w_tgt_next   = r_tgt;
    w_load_ir    = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (redirect) begin
          if (w_ack || !r_run) begin
            w_pc_next = redirect_pc;
          end else begin
            // Request stays on the bus at the old address until its ack is absorbed.
            w_next_state = S_DRAIN;
            w_tgt_next   = redirect_pc;
          end
        end else if (w_ack) begin
          w_load_ir    = 1'b1;
          w_pc_next    = r_pc + AW'(1);
          w_next_state = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          w_pc_next    = redirect_pc;
          w_next_state = S_FETCH;
        end else if (ir_ready) begin
          w_next_state = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (redirect) begin
          w_tgt_next = redirect_pc;
        end
        if (w_ack) begin
          w_pc_next    = redirect ? redirect_pc : r_tgt;
          w_next_state = S_FETCH;
        end
      end
      default: begin
        w_next_state = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run   <= 1'b0;
      r_pc    <= RESET_PC;
      r_tgt   <= RESET_PC;
      r_ir    <= '0;
      r_ir_pc <= '0;
    end else begin
      r_run <= 1'b1;
      r_pc  <= w_pc_next;
      r_tgt <= w_tgt_next;
      if (w_load_ir) begin
        r_ir    <= mem_rdata;
        r_ir_pc <= r_pc;
      end
    end
  end

  assign mem_req    = r_run & (r_state != S_HOLD);
  assign mem_addr   = r_pc;
  assign ir_valid   = (r_state == S_HOLD);
  assign ir_opcode  = r_ir[15:8];
  assign ir_operand = r_ir[7:0];
  assign ir_pc      = r_ir_pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios then random traffic, with a
// transaction-level fetch model feeding address and instruction scoreboards.
module tb_instr_fetch_unit;

  localparam int          AW  = 16;
  localparam logic [15:0] RPC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        ir_valid;
  logic        ir_ready;
  logic [7:0]  ir_opcode;
  logic [7:0]  ir_operand;
  logic [15:0] ir_pc;
  logic        redirect;
  logic [15:0] redirect_pc;

  instr_fetch_unit #(.AW(AW), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_opcode(ir_opcode),
    .ir_operand(ir_operand), .ir_pc(ir_pc),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] word;
  } instr_t;

  logic [15:0] qa[$];
  instr_t      qi[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] mem [0:65535];

  // Fetch model: next useful address, whether an instruction is held, and
  // whether the request now in flight belongs to a flushed path.
  logic [15:0] m_pc;
  bit          m_run;
  bit          m_full;
  bit          m_stale;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run   = 1'b0;
    m_pc    = RPC;
    m_full  = 1'b0;
    m_stale = 1'b0;
    qa.delete();
    qi.delete();
  endtask

  task automatic model_step(input logic ack, input logic ready, input logic redir,
                            input logic [15:0] rpc);
    bit requesting;
    instr_t it;
    if (!m_run) begin
      m_run = 1'b1;
      qa.push_back(m_pc);
      return;
    end
    requesting = !m_full;
    if (redir) begin
      m_full = 1'b0;
      m_pc   = rpc;
      if (requesting && !ack) begin
        m_stale = 1'b1;
      end else begin
        m_stale = 1'b0;
        qa.push_back(rpc);
      end
    end else if (requesting && ack) begin
      if (m_stale) begin
        m_stale = 1'b0;
        qa.push_back(m_pc);
      end else begin
        it.pc   = m_pc;
        it.word = mem[m_pc];
        qi.push_back(it);
        m_pc   = m_pc + 16'd1;
        m_full = 1'b1;
      end
    end else if (m_full && ready) begin
      m_full = 1'b0;
      qa.push_back(m_pc);
    end
  endtask

  task automatic cycle(input logic ack, input logic ready, input logic redir,
                       input logic [15:0] rpc);
    @(posedge clk);
    model_step(mem_ack, ir_ready, redirect, redirect_pc);
    #1;
    mem_ack     = ack;
    ir_ready    = ready;
    redirect    = redir;
    redirect_pc = rpc;
    mem_rdata   = ack ? mem[mem_addr] : 16'($urandom);
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    mem_ack     = 1'b0;
    ir_ready    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    mem_rdata   = '0;
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_ir_valid", 32'(ir_valid), 32'd0);
    check("rst_ir_opcode", 32'(ir_opcode), 32'd0);
    check("rst_ir_operand", 32'(ir_operand), 32'd0);
    check("rst_ir_pc", 32'(ir_pc), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: pops the scoreboards when the DUT presents a new request or a
  // new instruction, and checks hold/stability rules in between.
  logic        p_req, p_acc, p_valid, p_ready, p_redir;
  logic [15:0] p_addr, p_pc;
  logic [7:0]  p_op, p_opd;

  always @(negedge clk) begin
    logic [15:0] ea;
    instr_t      ei;
    if (rst) begin
      p_req = 1'b0; p_acc = 1'b0; p_valid = 1'b0; p_ready = 1'b0; p_redir = 1'b0;
      p_addr = '0; p_pc = '0; p_op = '0; p_opd = '0;
    end else begin
      if (ir_valid) check("no_req_while_valid", 32'(mem_req), 32'd0);
      if (mem_req && (!p_req || p_acc)) begin
        if (qa.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL req_addr: got request at %h expected no request at %0t", mem_addr, $time);
        end else begin
          ea = qa.pop_front();
          check("req_addr", 32'(mem_addr), 32'(ea));
        end
      end else if (mem_req && p_req) begin
        check("addr_stable", 32'(mem_addr), 32'(p_addr));
      end
      if (p_valid && (p_ready || p_redir)) begin
        check("ir_clear", 32'(ir_valid), 32'd0);
      end else if (p_valid) begin
        check("ir_held", 32'(ir_valid), 32'd1);
        check("ir_stable", {ir_pc, ir_opcode, ir_operand}, {p_pc, p_op, p_opd});
      end
      if (ir_valid && !p_valid) begin
        if (qi.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL ir_data: got instruction %h%h pc %h expected none at %0t",
                   ir_opcode, ir_operand, ir_pc, $time);
        end else begin
          ei = qi.pop_front();
          check("ir_data", {ir_pc, ir_opcode, ir_operand}, {ei.pc, ei.word});
        end
      end
      p_req = mem_req; p_acc = mem_req & mem_ack; p_addr = mem_addr;
      p_valid = ir_valid; p_ready = ir_ready; p_redir = redirect;
      p_pc = ir_pc; p_op = ir_opcode; p_opd = ir_operand;
    end
  end

  initial begin
    logic        ack, rdy, rd;
    logic [15:0] rpc;
    rst = 1'b1; mem_ack = 1'b0; ir_ready = 1'b0; redirect = 1'b0;
    redirect_pc = '0; mem_rdata = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1A05;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Ack two cycles after the first request, then stall the IR for 5 cycles.
    cycle(0, 0, 0, 16'h0000);
    cycle(0, 0, 0, 16'h0000);
    cycle(1, 0, 0, 16'h0000);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 16'h0000);
    cycle(0, 1, 0, 16'h0000);
    cycle(1, 1, 0, 16'h0000);
    cycle(0, 1, 0, 16'h0000);
    cycle(1, 1, 0, 16'h0000);
    cycle(0, 1, 0, 16'h0000);
    // Redirect while the fetch at 0003 is outstanding: drain, then 0040.
    cycle(0, 0, 1, 16'h0040);
    cycle(0, 0, 0, 16'h0000);
    cycle(0, 0, 0, 16'h0000);
    cycle(1, 0, 0, 16'h0000);
    cycle(0, 0, 0, 16'h0000);
    // Redirect coinciding with ack: data dropped, refetch at 0080.
    cycle(1, 0, 1, 16'h0080);
    cycle(0, 0, 0, 16'h0000);
    // Two redirects while draining; the latest (FFFF) wins, then wrap to 0000.
    cycle(0, 0, 1, 16'h1234);
    cycle(0, 0, 1, 16'hFFFF);
    cycle(1, 0, 0, 16'h0000);
    cycle(1, 1, 0, 16'h0000);
    cycle(0, 1, 0, 16'h0000);
    cycle(0, 0, 0, 16'h0000);
    // Reset mid-FETCH, then mid-HOLD.
    do_reset();
    cycle(0, 0, 0, 16'h0000);
    cycle(1, 0, 0, 16'h0000);
    cycle(0, 0, 0, 16'h0000);
    cycle(0, 0, 0, 16'h0000);
    do_reset();

    for (int i = 0; i < 3000; i++) begin
      if (i == 1000 || i == 2000) do_reset();
      ack = mem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 5) == 0);
      rdy = ($urandom_range(0, 1) == 0);
      rd  = ($urandom_range(0, 11) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (16'hFFFE | 16'($urandom_range(0, 1)))
                                        : 16'($urandom);
      cycle(ack, rdy, rd, rpc);
    end
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 16'h0000);
    @(negedge clk);
    #1;
    check("addr_queue_drained", 32'(qa.size()), 32'd0);
    check("instr_queue_drained", 32'(qi.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
